// File: rtl/lif_scheduler_pkg.sv
// Shared types and widths for the LIF neuron scheduler.
// The membrane state is MEM_W wide and the input current is CUR_W wide.
package lif_pkg;

  localparam int MEM_W = 16;
  localparam int CUR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/lif_scheduler_if.sv
// Control, current-fetch and monitor signals between the timestep driver and the scheduler.
// master drives requests, currents and the monitor select; slave is the scheduler.
interface lif_scheduler_if #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2
);

  logic                      start;
  logic                      clear;
  logic [lif_pkg::MEM_W-1:0] threshold;
  logic [IDX_W-1:0]          cur_addr;
  logic                      cur_rd;
  logic [lif_pkg::CUR_W-1:0] cur_data;
  logic                      busy;
  logic                      done;
  logic [NUM_NEURONS-1:0]    spikes;
  logic [IDX_W:0]            spike_cnt;
  logic [IDX_W-1:0]          mon_addr;
  logic [lif_pkg::MEM_W-1:0] mon_state;

  modport master (
    output start, clear, threshold, cur_data, mon_addr,
    input  cur_addr, cur_rd, busy, done, spikes, spike_cnt, mon_state
  );

  modport slave (
    input  start, clear, threshold, cur_data, mon_addr,
    output cur_addr, cur_rd, busy, done, spikes, spike_cnt, mon_state
  );

endinterface

// File: rtl/lif_scheduler_update.sv
// Combinational leak-integrate-fire step: leak, add current, saturate, compare, reset by subtraction.
// A zero threshold disables spiking.
module lif_update
  import lif_pkg::*;
#(
  parameter int DECAY_SHIFT = 2
) (
  input  logic [MEM_W-1:0] i_mem,
  input  logic [CUR_W-1:0] i_cur,
  input  logic [MEM_W-1:0] i_threshold,
  output logic [MEM_W-1:0] o_mem_next,
  output logic             o_spike
);

  logic [MEM_W-1:0] w_leaked;
  logic [MEM_W:0]   w_sum;
  logic [MEM_W-1:0] w_t;

  // The leak never underflows, so only the current add needs the extra carry bit.
  assign w_leaked   = i_mem - (i_mem >> DECAY_SHIFT);
  assign w_sum      = {1'b0, w_leaked} + {{(MEM_W + 1 - CUR_W){1'b0}}, i_cur};
  assign w_t        = w_sum[MEM_W] ? {MEM_W{1'b1}} : w_sum[MEM_W-1:0];
  assign o_spike    = (i_threshold != '0) && (w_t >= i_threshold);
  assign o_mem_next = o_spike ? (w_t - i_threshold) : w_t;

endmodule

// File: rtl/lif_scheduler.sv
// Sequences one shared LIF update over all neurons per timestep: FETCH/UPDATE per neuron, then DONE.
// A timestep takes 2*NUM_NEURONS+1 cycles from accepted start to done; start is ignored while busy.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2,
  parameter int DECAY_SHIFT = 2
) (
  input logic            clk,
  input logic            rst_n,
  lif_scheduler_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [MEM_W-1:0]       r_thr;
  logic [MEM_W-1:0]       r_mem [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] r_spk_acc;
  logic [IDX_W:0]         r_cnt_acc;
  logic [NUM_NEURONS-1:0] r_spikes;
  logic [IDX_W:0]         r_spike_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_cur_rd;
  logic [IDX_W-1:0]       r_cur_addr;
  logic [MEM_W-1:0]       r_mon;

  logic [MEM_W-1:0]       w_mem_cur;
  logic [MEM_W-1:0]       w_mem_next;
  logic                   w_spike;

  assign w_mem_cur = r_mem[r_idx];

  lif_update #(
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_update (
    .i_mem       (w_mem_cur),
    .i_cur       (bus.cur_data),
    .i_threshold (r_thr),
    .o_mem_next  (w_mem_next),
    .o_spike     (w_spike)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_thr       <= '0;
      r_spk_acc   <= '0;
      r_cnt_acc   <= '0;
      r_spikes    <= '0;
      r_spike_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cur_rd    <= 1'b0;
      r_cur_addr  <= '0;
      r_mon       <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) r_mem[i] <= '0;
    end else begin
      r_done   <= 1'b0;
      r_cur_rd <= 1'b0;
      // Non-blocking read: a same-cycle update of this index is seen next cycle.
      r_mon    <= r_mem[bus.mon_addr];
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_thr      <= bus.threshold;
            r_idx      <= '0;
            r_spk_acc  <= '0;
            r_cnt_acc  <= '0;
            r_busy     <= 1'b1;
            r_cur_rd   <= 1'b1;
            r_cur_addr <= '0;
            r_state    <= FETCH;
          end else if (bus.clear) begin
            for (int i = 0; i < NUM_NEURONS; i++) r_mem[i] <= '0;
          end
        end
        FETCH: begin
          r_state <= UPDATE;
        end
        UPDATE: begin
          r_mem[r_idx]     <= w_mem_next;
          r_spk_acc[r_idx] <= w_spike;
          r_cnt_acc        <= r_cnt_acc + {{IDX_W{1'b0}}, w_spike};
          if (r_idx == LAST) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx      <= r_idx + 1'b1;
            r_cur_rd   <= 1'b1;
            r_cur_addr <= r_idx + 1'b1;
            r_state    <= FETCH;
          end
        end
        DONE: begin
          r_spikes    <= r_spk_acc;
          r_spike_cnt <= r_cnt_acc;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cur_addr  = r_cur_addr;
  assign bus.cur_rd    = r_cur_rd;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.spikes    = r_spikes;
  assign bus.spike_cnt = r_spike_cnt;
  assign bus.mon_state = r_mon;

endmodule
